// File: rtl/nv_nvdla_mcif_pkg.sv
// rtl/nv_nvdla_mcif_pkg.sv - shared MCIF constants and pipe configuration check
package nv_nvdla_mcif_pkg;

  localparam int MCIF_RD_RSP_PD_W = 514;
  localparam int MCIF_PIPE_STAGES_MIN = 1;
  localparam int MCIF_PIPE_STAGES_MAX = 4;

  // True when the stage count is in range and the counter can hold a full pipe
  function automatic bit pipe_cfg_legal(int stages, int skid_en, int cnt_w);
    return (stages >= MCIF_PIPE_STAGES_MIN) && (stages <= MCIF_PIPE_STAGES_MAX) &&
           (skid_en == 0 || skid_en == 1) && ((stages + skid_en) < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_pipe_stage.sv
// rtl/nv_nvdla_mcif_pipe_stage.sv - one valid/ready register stage
module nv_nvdla_mcif_pipe_stage
  import nv_nvdla_mcif_pkg::*;
#(
  parameter int PD_WIDTH = MCIF_RD_RSP_PD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic [PD_WIDTH-1:0] in_pd,
  input  logic                down_rdy,
  output logic                vld,
  output logic [PD_WIDTH-1:0] pd,
  output logic                rdy
);

  // Stage can take a new word when it is empty or its word is leaving this edge
  assign rdy = down_rdy || !vld;

  // Valid flop: follows the feeding stage whenever this stage is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (rdy) begin
      vld <= in_vld;
    end
  end

  // Data flop: no reset, loads only on an actual transfer into this stage
  always_ff @(posedge clk) begin
    if (rdy && in_vld) begin
      pd <= in_pd;
    end
  end

endmodule

// File: rtl/nv_nvdla_mcif_rd_eg_skid_pipe.sv
// rtl/nv_nvdla_mcif_rd_eg_skid_pipe.sv - MCIF read egress skid buffer plus register pipe
module nv_nvdla_mcif_rd_eg_skid_pipe
  import nv_nvdla_mcif_pkg::*;
#(
  parameter int PD_WIDTH = MCIF_RD_RSP_PD_W,
  parameter int STAGES   = 1,
  parameter int SKID_EN  = 1,
  parameter int CNT_W    = 3
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [PD_WIDTH-1:0] in_pd,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [PD_WIDTH-1:0] out_pd,
  output logic [CNT_W-1:0]    pipe_cnt,
  output logic                pipe_idle
);

  if (!pipe_cfg_legal(STAGES, SKID_EN, CNT_W)) begin : g_bad_cfg
    $error("nv_nvdla_mcif_rd_eg_skid_pipe: illegal STAGES/SKID_EN/CNT_W combination");
  end

  // Index 0 is the source feeding stage 0; index i+1 is the output of stage i.
  logic [STAGES:0]     vld_chain;
  logic [STAGES:0]     rdy_chain;
  logic [PD_WIDTH-1:0] pd_chain [STAGES+1];
  logic                skid_vld;

  assign rdy_chain[STAGES] = out_rdy;
  assign out_vld           = vld_chain[STAGES];
  assign out_pd            = pd_chain[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    nv_nvdla_mcif_pipe_stage #(
      .PD_WIDTH (PD_WIDTH)
    ) u_stage (
      .clk      (nvdla_core_clk),
      .rst_n    (nvdla_core_rstn),
      .in_vld   (vld_chain[i]),
      .in_pd    (pd_chain[i]),
      .down_rdy (rdy_chain[i+1]),
      .vld      (vld_chain[i+1]),
      .pd       (pd_chain[i+1]),
      .rdy      (rdy_chain[i])
    );
  end

  if (SKID_EN != 0) begin : g_skid
    logic                skid_rdy_q;
    logic                skid_vld_q;
    logic [PD_WIDTH-1:0] skid_pd_q;
    logic                catch_pkt;

    // Packet accepted upstream while stage 0 is blocked lands in the skid
    assign catch_pkt = in_vld && skid_rdy_q && !rdy_chain[0];
    assign in_rdy    = skid_rdy_q;
    assign skid_vld  = skid_vld_q;

    // While the skid is empty stage 0 sees the input directly
    assign vld_chain[0] = skid_rdy_q ? in_vld : skid_vld_q;
    assign pd_chain[0]  = skid_rdy_q ? in_pd  : skid_pd_q;

    // Skid control: fill on catch, empty once stage 0 frees up
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        skid_vld_q <= 1'b0;
        skid_rdy_q <= 1'b1;
      end else begin
        skid_vld_q <= skid_vld_q ? !rdy_chain[0] : catch_pkt;
        skid_rdy_q <= skid_vld_q ? rdy_chain[0]  : !catch_pkt;
      end
    end

    // Skid data: captured only when a packet is actually caught
    always_ff @(posedge nvdla_core_clk) begin
      if (catch_pkt) begin
        skid_pd_q <= in_pd;
      end
    end
  end else begin : g_no_skid
    assign in_rdy       = rdy_chain[0];
    assign skid_vld     = 1'b0;
    assign vld_chain[0] = in_vld;
    assign pd_chain[0]  = in_pd;
  end

  // Occupancy: skid entry plus every valid stage
  always_comb begin
    pipe_cnt = CNT_W'(skid_vld);
    for (int i = 1; i <= STAGES; i++) begin
      pipe_cnt = pipe_cnt + CNT_W'(vld_chain[i]);
    end
  end

  assign pipe_idle = (pipe_cnt == '0) && !in_vld;

endmodule

// File: tb/tb_nv_nvdla_mcif_rd_eg_skid_pipe.sv
// tb/tb_nv_nvdla_mcif_rd_eg_skid_pipe.sv - self-checking bench for the egress skid pipe
module tb_nv_nvdla_mcif_rd_eg_skid_pipe;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;

  logic         a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_idle;
  logic [W-1:0] a_in_pd, a_out_pd;
  logic [2:0]   a_cnt;

  logic         b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_idle;
  logic [W-1:0] b_in_pd, b_out_pd;
  logic [2:0]   b_cnt;

  int n_checks;
  int n_fail;

  nv_nvdla_mcif_rd_eg_skid_pipe #(
    .PD_WIDTH (W), .STAGES (2), .SKID_EN (1), .CNT_W (3)
  ) dut_a (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .in_vld          (a_in_vld),
    .in_rdy          (a_in_rdy),
    .in_pd           (a_in_pd),
    .out_vld         (a_out_vld),
    .out_rdy         (a_out_rdy),
    .out_pd          (a_out_pd),
    .pipe_cnt        (a_cnt),
    .pipe_idle       (a_idle)
  );

  nv_nvdla_mcif_rd_eg_skid_pipe #(
    .PD_WIDTH (W), .STAGES (1), .SKID_EN (0), .CNT_W (3)
  ) dut_b (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .in_vld          (b_in_vld),
    .in_rdy          (b_in_rdy),
    .in_pd           (b_in_pd),
    .out_vld         (b_out_vld),
    .out_rdy         (b_out_rdy),
    .out_pd          (b_out_pd),
    .pipe_cnt        (b_cnt),
    .pipe_idle       (b_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    int acc;
    rst_n = 1'b0;
    a_in_vld = 0; a_in_pd = '0; a_out_rdy = 0;
    b_in_vld = 0; b_in_pd = '0; b_out_rdy = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (a_out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got %b want 0", a_out_vld); end
    n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
    n_checks++; if (a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", a_in_rdy); end
    n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", a_idle); end
    n_checks++; if (b_in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_rdy got %b want 1", b_in_rdy); end
    // hold three packets with downstream stalled, then reset mid-stream
    acc = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      a_in_vld = 1; a_in_pd = W'(j + 10); a_out_rdy = 0;
      #1;
      if (a_in_vld && a_in_rdy) acc++;
    end
    @(negedge clk);
    a_in_vld = 0;
    #1;
    n_checks++; if (a_cnt !== 3'(acc) || acc != 3) begin n_fail++; $display("FAIL hold_cnt got %0d accepted %0d want 3", a_cnt, acc); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_vld !== 1'b0) begin n_fail++; $display("FAIL midreset_out_vld got %b want 0", a_out_vld); end
    n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL midreset_cnt got %0d want 0", a_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL release_in_rdy got %b want 1", a_in_rdy); end
    // nothing may be replayed after reset
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      a_out_rdy = 1;
      #1;
      n_checks++; if (a_out_vld !== 1'b0) begin n_fail++; $display("FAIL no_replay cyc %0d out_vld %b want 0", j, a_out_vld); end
    end
  endtask

  task automatic test_streaming();
    bit exp_vld;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      a_out_rdy = 1;
      a_in_vld  = (j < 8);
      a_in_pd   = W'(j);
      #1;
      exp_vld = (j >= 2) && (j < 10);
      n_checks++; if (a_out_vld !== exp_vld) begin n_fail++; $display("FAIL stream_vld cyc %0d got %b want %b", j, a_out_vld, exp_vld); end
      if (exp_vld) begin
        n_checks++; if (a_out_pd !== W'(j - 2)) begin n_fail++; $display("FAIL stream_pd cyc %0d got %0d want %0d", j, a_out_pd, j - 2); end
      end
      n_checks++; if (a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_in_rdy cyc %0d got %b want 1", j, a_in_rdy); end
    end
    a_in_vld = 0;
  endtask

  task automatic test_backpressure();
    int acc;
    logic [W-1:0] got[$];
    bit exp_rdy;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      a_out_rdy = 0;
      a_in_vld  = 1;
      a_in_pd   = W'(100 + acc);
      #1;
      exp_rdy = (j < 3);
      n_checks++; if (a_in_rdy !== exp_rdy) begin n_fail++; $display("FAIL bp_in_rdy cyc %0d got %b want %b", j, a_in_rdy, exp_rdy); end
      if (a_in_vld && a_in_rdy) acc++;
    end
    n_checks++; if (acc != 3) begin n_fail++; $display("FAIL bp_accepted got %0d want 3", acc); end
    n_checks++; if (a_cnt !== 3'd3) begin n_fail++; $display("FAIL bp_cnt got %0d want 3", a_cnt); end
    for (int j = 0; j < 20 && got.size() < 3; j++) begin
      @(negedge clk);
      a_in_vld  = 0;
      a_out_rdy = 1;
      #1;
      if (a_out_vld) got.push_back(a_out_pd);
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_delivered got %0d want 3", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_checks++; if (got[k] !== W'(100 + k)) begin n_fail++; $display("FAIL bp_order idx %0d got %0d want %0d", k, got[k], 100 + k); end
    end
    @(negedge clk);
    #1;
    n_checks++; if (a_cnt !== 3'd0 || a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_drained cnt %0d in_rdy %b want 0/1", a_cnt, a_in_rdy); end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    bit acc_in, acc_out;
    int bad;
    bad = 0;
    for (int j = 0; j < 10000; j++) begin
      @(negedge clk);
      a_in_vld  = ($urandom_range(0, 3) != 0);
      a_out_rdy = ($urandom_range(0, 2) != 0);
      a_in_pd   = {$urandom, $urandom};
      #1;
      acc_in  = a_in_vld && a_in_rdy;
      acc_out = a_out_vld && a_out_rdy;
      n_checks++;
      if (a_cnt !== 3'(q.size())) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL rand_cnt cyc %0d got %0d want %0d", j, a_cnt, q.size());
      end
      n_checks++;
      if (a_idle !== (q.size() == 0 && !a_in_vld)) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL rand_idle cyc %0d got %b want %b", j, a_idle, (q.size() == 0 && !a_in_vld));
      end
      if (a_out_vld) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          if (bad++ < 10) $display("FAIL rand_spurious cyc %0d out_vld 1 with model empty", j);
        end else if (a_out_pd !== q[0]) begin
          n_fail++;
          if (bad++ < 10) $display("FAIL rand_pd cyc %0d got %h want %h", j, a_out_pd, q[0]);
        end
      end
      if (acc_out && q.size() > 0) void'(q.pop_front());
      if (acc_in) q.push_back(a_in_pd);
    end
    for (int j = 0; j < 20 && q.size() > 0; j++) begin
      @(negedge clk);
      a_in_vld = 0; a_out_rdy = 1;
      #1;
      if (a_out_vld) begin
        n_checks++; if (a_out_pd !== q[0]) begin n_fail++; $display("FAIL rand_drain_pd got %h want %h", a_out_pd, q[0]); end
        void'(q.pop_front());
      end
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_lost remaining %0d want 0", q.size()); end
  endtask

  task automatic test_no_skid();
    logic [W-1:0] q[$];
    bit exp_rdy;
    int bad;
    bad = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      b_in_vld  = $urandom_range(0, 1);
      b_out_rdy = $urandom_range(0, 1);
      b_in_pd   = {$urandom, $urandom};
      #1;
      exp_rdy = b_out_rdy || !b_out_vld;
      n_checks++;
      if (b_in_rdy !== exp_rdy) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL noskid_in_rdy cyc %0d got %b want %b", j, b_in_rdy, exp_rdy);
      end
      n_checks++;
      if (b_cnt !== 3'(q.size()) || (b_out_vld && q.size() > 0 && b_out_pd !== q[0])) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL noskid_model cyc %0d cnt %0d want %0d", j, b_cnt, q.size());
      end
      if (b_out_vld && b_out_rdy && q.size() > 0) void'(q.pop_front());
      if (b_in_vld && b_in_rdy) q.push_back(b_in_pd);
    end
    repeat (3) begin
      @(negedge clk);
      b_in_vld = 0; b_out_rdy = 1;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      b_out_rdy = 0; b_in_vld = 1; b_in_pd = W'(500 + j);
    end
    #1;
    n_checks++; if (b_cnt !== 3'd1) begin n_fail++; $display("FAIL noskid_sat_cnt got %0d want 1", b_cnt); end
    n_checks++; if (b_in_rdy !== 1'b0) begin n_fail++; $display("FAIL noskid_sat_in_rdy got %b want 0", b_in_rdy); end
    n_checks++; if (b_out_pd !== W'(500)) begin n_fail++; $display("FAIL noskid_sat_pd got %0d want 500", b_out_pd); end
    @(negedge clk);
    b_in_vld = 0; b_out_rdy = 1;
  endtask

  task automatic test_idle();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      a_in_vld = 0; a_out_rdy = 1;
    end
    #1;
    n_checks++; if (a_idle !== 1'b1 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL idle_drained idle %b cnt %0d want 1/0", a_idle, a_cnt); end
    a_in_vld = 1; a_in_pd = W'(77);
    #1;
    n_checks++; if (a_idle !== 1'b0) begin n_fail++; $display("FAIL idle_same_cycle got %b want 0", a_idle); end
    a_in_vld = 0;
    #1;
    n_checks++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL idle_deassert got %b want 1", a_idle); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_no_skid();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
